// File: rtl/axis_sample_bridge.sv
// ADC-to-DAC AXI-Stream bridge: decimation, width map with rounding/saturation,
// first-word-fall-through elastic FIFO and saturating overflow statistics.
module axis_sample_bridge #(
  parameter int IN_W         = 12,
  parameter int OUT_W        = 14,
  parameter int DEPTH        = 8,
  parameter int DROP_ON_FULL = 0,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [IN_W-1:0]           s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [OUT_W-1:0]          m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic [7:0]                decim,
  input  logic                      clear_stats,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [CNT_W-1:0]          overflow_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  // Shift amounts are clamped so both width-map branches elaborate legally.
  localparam int SH    = (IN_W > OUT_W) ? IN_W - OUT_W : 1;
  localparam int ZW    = (OUT_W > IN_W) ? OUT_W - IN_W : 0;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  function automatic logic [OUT_W-1:0] round_sat(input logic [IN_W-1:0] x);
    logic [OUT_W-1:0] top;
    logic             rb;
    top = OUT_W'(x >> SH);
    rb  = x[SH-1];
    if ((&top) && rb) round_sat = '1;
    else              round_sat = top + OUT_W'(rb);
  endfunction

  function automatic logic [OUT_W-1:0] map_sample(input logic [IN_W-1:0] x);
    if (OUT_W >= IN_W) map_sample = OUT_W'(x) << ZW;
    else               map_sample = round_sat(x);
  endfunction

  logic                 run;
  logic [7:0]           dcnt;
  logic [LVL_W-1:0]     level;
  logic [LVL_W-1:0]     level_nxt;
  logic [LVL_W-1:0]     mem_cnt;
  logic                 full;
  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;
  logic [OUT_W-1:0]     mem [DEPTH];
  logic [CNT_W-1:0]     ovf_cnt;

  logic                 accept;
  logic                 vld_p0;
  logic [OUT_W-1:0]     data_p0;
  logic                 wr_p0;
  logic                 ovf_p0;
  logic                 rd_p1;
  logic                 load_p1;
  logic                 pop;
  logic                 bypass;
  logic                 push;
  logic                 vld_p1;
  logic [OUT_W-1:0]     data_p1;

  assign s_axis_tready = run && ((DROP_ON_FULL != 0) || !full);
  assign m_axis_tvalid = vld_p1;
  assign m_axis_tdata  = data_p1;
  assign fifo_level    = level;
  assign overflow_cnt  = ovf_cnt;

  // Stage p0: accept, decimate, map width, decide write/drop
  always_comb begin
    accept    = s_axis_tvalid && s_axis_tready;
    vld_p0    = accept && (dcnt == 8'd0);
    data_p0   = map_sample(s_axis_tdata);
    wr_p0     = vld_p0 && !full;
    ovf_p0    = vld_p0 && full;
    rd_p1     = vld_p1 && m_axis_tready;
    mem_cnt   = level - LVL_W'(vld_p1);
    // The output register refills whenever it is empty or being drained.
    load_p1   = !vld_p1 || rd_p1;
    pop       = load_p1 && (mem_cnt != '0);
    bypass    = load_p1 && (mem_cnt == '0) && wr_p0;
    push      = wr_p0 && !bypass;
    level_nxt = level + LVL_W'(wr_p0) - LVL_W'(rd_p1);
  end

  // Stage p1: FIFO bookkeeping and first-word-fall-through output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run     <= 1'b0;
      dcnt    <= '0;
      level   <= '0;
      full    <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ovf_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (accept) dcnt <= (dcnt >= decim) ? 8'd0 : dcnt + 8'd1;
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (load_p1) begin
        if (pop) begin
          vld_p1  <= 1'b1;
          data_p1 <= mem[rptr];
        end else if (bypass) begin
          vld_p1  <= 1'b1;
          data_p1 <= data_p0;
        end else begin
          vld_p1  <= 1'b0;
        end
      end
      level <= level_nxt;
      full  <= (level_nxt == FULL_LVL);
      if (clear_stats)                  ovf_cnt <= '0;
      else if (ovf_p0 && ~&ovf_cnt)     ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wptr] <= data_p0;
  end

endmodule

// File: tb/tb_axis_sample_bridge.sv
// Directed bench: default 12->14 backpressure bridge (a) and 12->8 drop-mode bridge (b).
module tb_axis_sample_bridge;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [11:0] a_tdata;
  logic        a_tvalid, a_tready;
  logic [13:0] a_mdata;
  logic        a_mvalid, a_mready;
  logic [7:0]  a_decim;
  logic        a_clear;
  logic [3:0]  a_level;
  logic [15:0] a_ovf;

  logic [11:0] b_tdata;
  logic        b_tvalid, b_tready;
  logic [7:0]  b_mdata;
  logic        b_mvalid, b_mready;
  logic [7:0]  b_decim;
  logic        b_clear;
  logic [3:0]  b_level;
  logic [15:0] b_ovf;

  int checks = 0;
  int errors = 0;

  logic [11:0] src[$];
  logic [13:0] expq[$];
  int a_sent, a_got, a_bad, dswitch;

  always #5 clk = ~clk;

  axis_sample_bridge dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid), .s_axis_tready(a_tready),
    .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid), .m_axis_tready(a_mready),
    .decim(a_decim), .clear_stats(a_clear),
    .fifo_level(a_level), .overflow_cnt(a_ovf)
  );

  axis_sample_bridge #(.IN_W(12), .OUT_W(8), .DEPTH(8), .DROP_ON_FULL(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
    .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready),
    .decim(b_decim), .clear_stats(b_clear),
    .fifo_level(b_level), .overflow_cnt(b_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives src[] into bridge a and scores every completed output transfer against expq[].
  task automatic run_a(input int cycles);
    logic        acc, rdv;
    logic [13:0] d;
    for (int c = 0; c < cycles; c++) begin
      a_tvalid = (a_sent < src.size());
      a_tdata  = a_tvalid ? src[a_sent] : 12'h000;
      if (dswitch >= 0 && a_sent >= dswitch) a_decim = 8'd1;
      acc = a_tvalid & a_tready;
      rdv = a_mvalid & a_mready;
      d   = a_mdata;
      step();
      if (acc) a_sent++;
      if (rdv) begin
        if (a_got >= expq.size() || d !== expq[a_got]) a_bad++;
        a_got++;
      end
    end
    a_tvalid = 1'b0;
  endtask

  task automatic reset_run();
    src.delete();
    expq.delete();
    a_sent = 0; a_got = 0; a_bad = 0; dswitch = -1;
  endtask

  initial begin
    logic [11:0] rin [4];
    logic [7:0]  rexp[4];
    rin[0] = 12'h7F7; rexp[0] = 8'h7F;
    rin[1] = 12'h7F8; rexp[1] = 8'h80;
    rin[2] = 12'hFF8; rexp[2] = 8'hFF;
    rin[3] = 12'h008; rexp[3] = 8'h01;

    rst_n = 1'b0;
    a_tdata = 12'h000; a_tvalid = 1'b1; a_mready = 1'b0; a_decim = 8'd0; a_clear = 1'b0;
    b_tdata = 12'h000; b_tvalid = 1'b1; b_mready = 1'b0; b_decim = 8'd0; b_clear = 1'b0;
    reset_run();

    // Reset held three cycles with valid asserted
    repeat (3) step();
    check("rst_a_tready", 32'(a_tready), 32'd0);
    check("rst_a_mvalid", 32'(a_mvalid), 32'd0);
    check("rst_a_level",  32'(a_level),  32'd0);
    check("rst_a_mdata",  32'(a_mdata),  32'd0);
    check("rst_b_tready", 32'(b_tready), 32'd0);
    check("rst_b_ovf",    32'(b_ovf),    32'd0);
    rst_n = 1'b1; a_tvalid = 1'b0; b_tvalid = 1'b0;
    check("rel_a_tready_same", 32'(a_tready), 32'd0);
    step();
    check("rel_a_tready", 32'(a_tready), 32'd1);
    check("rel_b_tready", 32'(b_tready), 32'd1);

    // Rounding and saturation on the 12->8 bridge
    b_mready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_tdata = rin[i]; b_tvalid = 1'b1;
      step();
      b_tvalid = 1'b0;
      check("round_vld", 32'(b_mvalid), 32'd1);
      check("round_data", 32'(b_mdata), 32'(rexp[i]));
      step();
    end
    check("round_drained", 32'(b_mvalid), 32'd0);

    // Single passthrough sample, one cycle latency
    a_mready = 1'b1;
    a_tdata = 12'hABC; a_tvalid = 1'b1;
    step();
    a_tvalid = 1'b0;
    check("pass_vld",  32'(a_mvalid), 32'd1);
    check("pass_data", 32'(a_mdata),  32'h2AF0);
    step();
    check("pass_empty", 32'(a_mvalid), 32'd0);

    // Full-range stream 0x000..0xFFF
    reset_run();
    for (int i = 0; i < 4096; i++) begin
      src.push_back(12'(i));
      expq.push_back(14'(i) << 2);
    end
    run_a(4105);
    check("stream_count", 32'(a_got), 32'd4096);
    check("stream_bad",   32'(a_bad), 32'd0);
    check("stream_idle",  32'(a_mvalid), 32'd0);

    // Backpressure: 10 samples into 8 entries with the sink stalled
    reset_run();
    for (int i = 0; i < 10; i++) begin
      src.push_back(12'h100 + 12'(i));
      expq.push_back((14'h100 + 14'(i)) << 2);
    end
    a_mready = 1'b0;
    run_a(12);
    check("bp_accepts", 32'(a_sent),   32'd8);
    check("bp_tready",  32'(a_tready), 32'd0);
    check("bp_level",   32'(a_level),  32'd8);
    check("bp_ovf",     32'(a_ovf),    32'd0);
    check("bp_head",    32'(a_mdata),  32'h400);
    a_mready = 1'b1;
    run_a(30);
    check("bp_count", 32'(a_got), 32'd10);
    check("bp_bad",   32'(a_bad), 32'd0);
    check("bp_level_end", 32'(a_level), 32'd0);

    // Drop mode: 12 samples into 8 entries, 4 counted as overflow
    b_mready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      b_tdata = 12'(k + 1) << 4; b_tvalid = 1'b1;
      step();
    end
    b_tvalid = 1'b0;
    check("drop_level",  32'(b_level),  32'd8);
    check("drop_ovf",    32'(b_ovf),    32'd4);
    check("drop_tready", 32'(b_tready), 32'd1);
    check("drop_head",   32'(b_mdata),  32'h01);
    b_tdata = 12'hEE0; b_tvalid = 1'b1; b_clear = 1'b1;
    step();
    b_tvalid = 1'b0; b_clear = 1'b0;
    check("drop_clear", 32'(b_ovf), 32'd0);
    b_tvalid = 1'b1;
    step();
    b_tvalid = 1'b0;
    check("drop_after_clear", 32'(b_ovf), 32'd1);
    b_mready = 1'b1;
    step();
    check("drop_second", 32'(b_mdata), 32'h02);
    repeat (8) step();
    check("drop_drained_lvl", 32'(b_level),  32'd0);
    check("drop_drained_vld", 32'(b_mvalid), 32'd0);

    // Decimation by 4, then decim lowered to 1 while dcnt==3
    reset_run();
    for (int i = 0; i < 16; i++) src.push_back(12'(i));
    for (int i = 100; i < 108; i++) src.push_back(12'(i));
    expq.push_back(14'd0);   expq.push_back(14'd16);
    expq.push_back(14'd32);  expq.push_back(14'd48);
    expq.push_back(14'd400); expq.push_back(14'd416); expq.push_back(14'd424);
    a_decim = 8'd3;
    dswitch = 19;
    run_a(30);
    check("decim_sent",  32'(a_sent), 32'd24);
    check("decim_count", 32'(a_got),  32'd7);
    check("decim_bad",   32'(a_bad),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_sample_bridge.md
Name: axis_sample_bridge

Overview:
- Parametrised successor to the fixed 12-to-14-bit ADC→DAC passthrough.
- Sits between an ADC AXI-Stream master (e.g. pmod_ad2) and a DAC AXI-Stream slave (e.g. pmod_da4).
- Adds generic width adaptation with rounding/saturation, a decimation stage, an elastic FIFO that decouples the I2C and SPI sample rates, and overflow statistics.
- Selectable behaviour on a full FIFO: backpressure the source, or drop the sample and count it.

Parameters:
- IN_W, 12, input sample width (unsigned straight binary), ≥2
- OUT_W, 14, output sample width, ≥2
- DEPTH, 8, FIFO entries; power of 2, ≥2
- DROP_ON_FULL, 0, 0 = backpressure source when full; 1 = s_axis_tready held high, excess samples dropped and counted
- CNT_W, 16, overflow counter width

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset
- s_axis_tdata  in  IN_W  ADC sample
- s_axis_tvalid  in  1  sample valid
- s_axis_tready  out  1  bridge can accept
- m_axis_tdata  out  OUT_W  DAC sample
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  DAC accepts
- decim  in  8  keep 1 of every decim+1 accepted samples; 0 = keep all
- clear_stats  in  1  synchronous clear of overflow_cnt
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy
- overflow_cnt  out  CNT_W  dropped-sample count, saturating

Behaviour:
- Clocking/reset: one clock, clk; rst_n is synchronous, active-low.
- While rst_n low:
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0
  - fifo_level=0, overflow_cnt=0
  - decimation counter=0, FIFO pointers=0
- Accept: in = s_axis_tvalid & s_axis_tready.
- s_axis_tready:
  - DROP_ON_FULL=0: !full, from registered level only; no combinational path from m_axis_tready.
  - DROP_ON_FULL=1: 1 whenever out of reset.
- Decimation:
  - dcnt counts accepts. Sample is kept when dcnt==0.
  - After each accept: dcnt <= (dcnt >= decim) ? 0 : dcnt+1. The ≥ compare makes a mid-run decrease of decim safe, with no long wrap.
  - Discarded samples are not overflows.
- Width map, applied to kept samples before the FIFO write:
  - OUT_W ≥ IN_W: out = {in, (OUT_W-IN_W) zeros} (MSB-aligned; 12→14 gives {x,2'b00}).
  - OUT_W < IN_W: out = in[IN_W-1 -: OUT_W] + in[IN_W-OUT_W-1] (round half up). Saturate to all-ones when the top field is all-ones and the round bit is set.
- FIFO:
  - Write = kept & !full. Read = m_axis_tvalid & m_axis_tready.
  - Simultaneous read and write: level unchanged, both occur.
  - Write when full with DROP_ON_FULL=1: sample discarded and overflow_cnt += 1, even if a read occurs the same cycle (full is a registered flag).
  - Pointers wrap modulo DEPTH.
- Output register: first-word-fall-through.
  - m_axis_tdata/m_axis_tvalid are registered; latency is 1 cycle from accept to m_axis_tvalid when the FIFO is empty.
  - m_axis_tdata is held stable while m_axis_tvalid & !m_axis_tready.
  - m_axis_tvalid deasserts only after a completed read with the FIFO empty.
- Storage: output register counts as one of the DEPTH entries. fifo_level = entries held, including the output register; full = (fifo_level==DEPTH).
- overflow_cnt:
  - Saturates at 2^CNT_W-1.
  - clear_stats has priority over an increment in the same cycle (result 0).
- No state machine beyond the FIFO and decimation counter. Mid-stream reset discards all contents; the first accept after release is kept (dcnt=0).

Test Plan:
- Reset: hold rst_n=0 3 cycles with s_axis_tvalid=1 → s_axis_tready=0, m_axis_tvalid=0, fifo_level=0. Release rst_n → s_axis_tready=1 next cycle.
- Defaults, passthrough: send 0xABC, decim=0, m_axis_tready=1 → m_axis_tdata=0x2AF0 one cycle after accept. Stream 0x000..0xFFF → every output = in<<2, in order, none lost.
- Rounding/saturation: IN_W=12, OUT_W=8. Inputs 0x7F7→0x7F, 0x7F8→0x80, 0xFF8→0xFF (saturated), 0x008→0x01.
- Backpressure (DROP_ON_FULL=0, DEPTH=8): m_axis_tready=0, stream 10 samples → after 8 accepts s_axis_tready=0 and fifo_level=8, overflow_cnt=0. Raise m_axis_tready → all 10 emerge in order.
- Drop mode (DROP_ON_FULL=1): m_axis_tready=0, 12 samples → fifo_level=8, overflow_cnt=4, output holds sample 0. Pulse clear_stats in the same cycle as a 13th drop → overflow_cnt=0.
- Decimation: decim=3, inputs 0..15 → outputs 0,4,8,12 (shifted). Change decim to 1 when dcnt=3 → next kept sample is the following accept, then every 2nd.
